// File: rtl/sram_arbiter_if.sv
// Bus bundle between the CPU ports and one SRAM bank.
// The slave side is the arbiter. The master side is the CPU together with the
// board pins/SRAM model.
interface sram_arbiter_if #(
  parameter int ADDR_W = 20
);
  // instruction-fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [31:0]       if_rdata;
  // data port
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  // SRAM pins (the tri-state is resolved by the board top)
  logic [31:0]       ram_data_i;
  logic [31:0]       ram_data_o;
  logic              ram_data_oe;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_be_n;
  logic              ram_ce_n;
  logic              ram_oe_n;
  logic              ram_we_n;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata, ram_data_i,
    output if_ack, if_rdata, mem_ack, mem_rdata,
    output ram_data_o, ram_data_oe, ram_addr, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata, ram_data_i,
    input  if_ack, if_rdata, mem_ack, mem_rdata,
    input  ram_data_o, ram_data_oe, ram_addr, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one asynchronous 32-bit SRAM bank between the instruction-fetch port
// and the data port. It sequences the read and write strobe timing and
// registers every pin and ack.
// Optional macro SRAM_ARB_RR_EN: when two requests arrive together, grant
// them round-robin. When the macro is undefined, the data port has fixed
// priority.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  sram_arbiter_if.slave  bus
);

  // Counter only needs to reach WAIT_CYCLES; it restarts on every state entry.
  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE
  } state_e;

  typedef enum logic { P_IF = 1'b0, P_MEM = 1'b1 } port_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  port_e             port_q, port_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdo_q, wdo_d;
  logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic [3:0]        be_n_q, be_n_d;
  logic              doe_q, doe_d;
  logic              if_ack_q, if_ack_d, mem_ack_q, mem_ack_d;
  logic [31:0]       if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic              grant_vld, grant_mem;
`ifdef SRAM_ARB_RR_EN
  port_e             last_q, last_d;
`endif

  // Next state, latched request fields, and pin values for the next state
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    port_d      = port_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdo_d       = wdo_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    grant_vld   = bus.if_req | bus.mem_req;
`ifdef SRAM_ARB_RR_EN
    last_d      = last_q;
    // Data port wins a contest only if IF was granted last.
    grant_mem   = bus.mem_req & (~bus.if_req | (last_q == P_IF));
`else
    grant_mem   = bus.mem_req;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          port_d = grant_mem ? P_MEM : P_IF;
`ifdef SRAM_ARB_RR_EN
          last_d = port_d;
`endif
          if (grant_mem) begin
            addr_d = bus.mem_addr;
            be_d   = bus.mem_be;
            if (bus.mem_we) begin
              wdo_d   = bus.mem_wdata;
              // A write with no lanes enabled completes without touching SRAM.
              state_d = (bus.mem_be == 4'h0) ? S_DONE : S_WR_SETUP;
            end else begin
              state_d = S_RD;
            end
          end else begin
            addr_d  = bus.if_addr;
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          if (port_q == P_MEM) mem_rdata_d = bus.ram_data_i;
          else                 if_rdata_d  = bus.ram_data_i;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR_SETUP: state_d = S_WR_PULSE;
      S_WR_PULSE: begin
        if (cnt_q == CNT_LAST) state_d = S_WR_HOLD;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_WR_HOLD: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Pins are registered, so decode them from the state being entered.
    ce_n_d = 1'b1;
    oe_n_d = 1'b1;
    we_n_d = 1'b1;
    be_n_d = 4'hF;
    doe_d  = 1'b0;
    unique case (state_d)
      S_RD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = 4'h0;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        ce_n_d = 1'b0;
        be_n_d = ~be_d;
        doe_d  = 1'b1;
      end
      S_WR_PULSE: begin
        ce_n_d = 1'b0;
        we_n_d = 1'b0;
        be_n_d = ~be_d;
        doe_d  = 1'b1;
      end
      default: ;
    endcase

    // DONE is entered from a different state, so each ack is a single-cycle pulse.
    if_ack_d  = (state_d == S_DONE) && (port_d == P_IF);
    mem_ack_d = (state_d == S_DONE) && (port_d == P_MEM);
  end

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      port_q      <= P_IF;
      be_q        <= 4'h0;
      addr_q      <= '0;
      wdo_q       <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= 4'hF;
      doe_q       <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
`ifdef SRAM_ARB_RR_EN
      last_q      <= P_IF;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      port_q      <= port_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdo_q       <= wdo_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      be_n_q      <= be_n_d;
      doe_q       <= doe_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
`ifdef SRAM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  // The arbiter must never drive the data bus while the SRAM is driving it.
  a_no_bus_contention: assert property (@(posedge clk) disable iff (!rst_n)
    !(doe_q && !oe_n_q));

  assign bus.ram_ce_n    = ce_n_q;
  assign bus.ram_oe_n    = oe_n_q;
  assign bus.ram_we_n    = we_n_q;
  assign bus.ram_be_n    = be_n_q;
  assign bus.ram_data_oe = doe_q;
  assign bus.ram_addr    = addr_q;
  assign bus.ram_data_o  = wdo_q;
  assign bus.if_ack      = if_ack_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.mem_ack     = mem_ack_q;
  assign bus.mem_rdata   = mem_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: request tasks push the expected ack
// cycle and data, and a forked monitor pops and compares on each ack.
module tb_sram_arbiter;
  localparam int AW = 20;
  localparam int WC = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_arbiter_if #(.ADDR_W(AW)) bus ();

  sram_arbiter #(.WAIT_CYCLES(WC), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Small asynchronous SRAM model, indexed by the low address bits
  logic [31:0] sram [0:255];
  assign bus.ram_data_i = (!bus.ram_ce_n && !bus.ram_oe_n) ? sram[bus.ram_addr[7:0]] : 32'h0;

  typedef struct {
    int          cyc;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t if_q[$];
  exp_t mem_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_oe = 0, n_we = 0, n_we_doe = 0, n_ce = 0, n_ack = 0;
  logic [3:0] be_n_we = 4'hF;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // SRAM write port: commit enabled lanes while ce_n and we_n are both low
  task automatic sram_model();
    forever begin
      @(posedge clk);
      if (!bus.ram_ce_n && !bus.ram_we_n)
        for (int b = 0; b < 4; b++)
          if (!bus.ram_be_n[b]) sram[bus.ram_addr[7:0]][b*8 +: 8] = bus.ram_data_o[b*8 +: 8];
    end
  endtask

  // Pin statistics plus scoreboard pops, sampled on the falling edge
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!bus.ram_oe_n) n_oe++;
      if (!bus.ram_ce_n) n_ce++;
      if (!bus.ram_we_n) begin
        n_we++;
        be_n_we = bus.ram_be_n;
        if (bus.ram_data_oe) n_we_doe++;
      end
      if (bus.if_ack || bus.mem_ack) n_ack++;
      if (rst_n && bus.if_ack) begin
        if (if_q.size() == 0) chk("unexpected if_ack", bus.if_ack, 0);
        else begin
          e = if_q.pop_front();
          chk("if_ack cycle", cyc, e.cyc);
          if (e.chk_data) chk("if_rdata", bus.if_rdata, e.data);
        end
      end
      if (rst_n && bus.mem_ack) begin
        if (mem_q.size() == 0) chk("unexpected mem_ack", bus.mem_ack, 0);
        else begin
          e = mem_q.pop_front();
          chk("mem_ack cycle", cyc, e.cyc);
          if (e.chk_data) chk("mem_rdata", bus.mem_rdata, e.data);
        end
      end
    end
  endtask

  // IF read: the caller starts just after a rising edge. lat is the number of cycles until the ack.
  task automatic if_rd(input logic [AW-1:0] a, input logic [31:0] d, input int lat);
    exp_t e;
    int   k;
    e.cyc = cyc + lat; e.chk_data = 1'b1; e.data = d;
    if_q.push_back(e);
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.if_ack && k < 100);
    if (!bus.if_ack) chk("if_ack timeout", bus.if_ack, 1);
    step();
    bus.if_req = 1'b0;
  endtask

  task automatic mem_acc(input logic we, input logic [3:0] be, input logic [AW-1:0] a,
                         input logic [31:0] wd, input logic [31:0] d, input int lat);
    exp_t e;
    int   k;
    e.cyc = cyc + lat; e.chk_data = !we; e.data = d;
    mem_q.push_back(e);
    bus.mem_we    = we;
    bus.mem_be    = be;
    bus.mem_addr  = a;
    bus.mem_wdata = wd;
    bus.mem_req   = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.mem_ack && k < 100);
    if (!bus.mem_ack) chk("mem_ack timeout", bus.mem_ack, 1);
    step();
    bus.mem_req = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int s_oe, s_we, s_wd, s_ce, s_ack;
    for (int i = 0; i < 256; i++) sram[i] = 32'h0;
    sram[8'h10] = 32'h3C08_8000;
    sram[8'h20] = 32'h1234_5678;
    sram[8'h30] = 32'hAAAA_0030;
    sram[8'h40] = 32'hBBBB_0040;
    sram[8'h50] = 32'hCCCC_0050;
    sram[8'h60] = 32'hDDDD_0060;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_be = 4'h0;
    bus.mem_addr = '0; bus.mem_wdata = '0;
    fork
      sram_model();
      monitor();
    join_none

    // Reset, then 20 idle cycles
    repeat (3) step();
    rst_n = 1'b1;
    s_ack = n_ack; s_ce = n_ce;
    repeat (20) step();
    chk("idle ce_n", bus.ram_ce_n, 1);
    chk("idle oe_n", bus.ram_oe_n, 1);
    chk("idle we_n", bus.ram_we_n, 1);
    chk("idle be_n", bus.ram_be_n, 4'hF);
    chk("idle data_oe", bus.ram_data_oe, 0);
    chk("reset ram_addr", bus.ram_addr, 0);
    chk("reset ram_data_o", bus.ram_data_o, 0);
    chk("reset if_rdata", bus.if_rdata, 0);
    chk("reset mem_rdata", bus.mem_rdata, 0);
    chk("idle ack count", n_ack - s_ack, 0);
    chk("idle ce_n low count", n_ce - s_ce, 0);

    // IF read, 3-cycle latency, oe_n low for exactly 2 cycles
    s_oe = n_oe;
    if_rd(20'h00010, 32'h3C08_8000, 3);
    chk("if read oe_n cycles", n_oe - s_oe, 2);
    chk("idle ram_addr holds", bus.ram_addr, 20'h00010);
    chk("idle ce_n after read", bus.ram_ce_n, 1);

    // Partial write, then read back
    step();
    s_we = n_we; s_wd = n_we_doe;
    mem_acc(1'b1, 4'b0011, 20'h00020, 32'hDEAD_BEEF, 32'h0, 5);
    chk("write we_n cycles", n_we - s_we, 2);
    chk("write we_n inside data_oe", n_we_doe - s_wd, 2);
    chk("write be_n", be_n_we, 4'b1100);
    step();
    mem_acc(1'b0, 4'hF, 20'h00020, 32'h0, 32'h1234_BEEF, 3);

    // Simultaneous requests
    step();
`ifdef SRAM_ARB_RR_EN
    fork
      begin
        mem_acc(1'b0, 4'hF, 20'h00030, 32'h0, 32'hAAAA_0030, 3);
        mem_acc(1'b0, 4'hF, 20'h00050, 32'h0, 32'hCCCC_0050, 7);
      end
      begin
        if_rd(20'h00040, 32'hBBBB_0040, 7);
        if_rd(20'h00060, 32'hDDDD_0060, 7);
      end
    join
`else
    fork
      mem_acc(1'b0, 4'hF, 20'h00030, 32'h0, 32'hAAAA_0030, 3);
      if_rd(20'h00040, 32'hBBBB_0040, 7);
    join
`endif

    // Write with no byte lanes enabled: ack next cycle, SRAM untouched
    step();
    s_ce = n_ce; s_we = n_we;
    mem_acc(1'b1, 4'h0, 20'h00070, 32'hFFFF_FFFF, 32'h0, 1);
    chk("be0 ce_n low count", n_ce - s_ce, 0);
    chk("be0 we_n low count", n_we - s_we, 0);

    // Reset during the write pulse
    step();
    bus.mem_we = 1'b1; bus.mem_be = 4'hF; bus.mem_addr = 20'h00080;
    bus.mem_wdata = 32'h55AA_55AA; bus.mem_req = 1'b1;
    step();
    step();
    chk("pulse we_n low", bus.ram_we_n, 0);
    rst_n = 1'b0;
    bus.mem_req = 1'b0;
    step();
    chk("abort we_n", bus.ram_we_n, 1);
    chk("abort data_oe", bus.ram_data_oe, 0);
    chk("abort ce_n", bus.ram_ce_n, 1);
    s_ack = n_ack;
    step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("abort ack count", n_ack - s_ack, 0);
    if_rd(20'h00010, 32'h3C08_8000, 3);

    repeat (3) step();
    chk("if scoreboard drained", if_q.size(), 0);
    chk("mem scoreboard drained", mem_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
